// File: rtl/fetch_buffer.sv
// fetch_buffer: in-order instruction prefetch queue between I-mem and IF/ID.
// Define FETCH_BUFFER_BYPASS_EN to forward a response to out_* when empty.
module fetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     redirect_i,
    input  logic [31:0]              redirect_pc_i,
    output logic                     mem_req_o,
    output logic [31:0]              mem_addr_o,
    input  logic                     mem_ack_i,
    input  logic                     mem_rvalid_i,
    input  logic [31:0]              mem_rdata_i,
    output logic                     out_valid_o,
    output logic [31:0]              out_pc_o,
    output logic [31:0]              out_instr_o,
    input  logic                     out_ready_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   fpc_q;
    logic [31:0]   tag_mem [DEPTH];
    logic [31:0]   pc_mem [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic [AW-1:0] tag_rd_q, tag_wr_q;
    logic [AW-1:0] rd_q, wr_q;
    logic [CW-1:0] count_q, outst_q, discard_q;

    logic          accept, rsp_take, rsp_drop;
    logic          push, pop, bypass, buf_valid;
    logic [CW:0]   occupancy;
    logic [CW-1:0] inflight;
    logic          unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc_i[1:0];

    // every outstanding request already owns a buffer slot
    assign occupancy = {1'b0, count_q} + {1'b0, outst_q};
    assign mem_req_o = rst_n_i & !redirect_i
                     & (discard_q == '0)
                     & (occupancy < DEPTH_W);
    assign mem_addr_o = fpc_q;

    assign accept   = mem_req_o & mem_ack_i;
    assign rsp_take = mem_rvalid_i & (discard_q == '0)
                    & (outst_q != '0);
    assign rsp_drop = mem_rvalid_i & (discard_q != '0);
    assign inflight = discard_q + outst_q;

    assign buf_valid = (count_q != '0) & !redirect_i;
    assign pop       = buf_valid & out_ready_i;
    assign push      = rsp_take & !redirect_i
                     & !(bypass & out_ready_i);

`ifdef FETCH_BUFFER_BYPASS_EN
    assign bypass = rsp_take & (count_q == '0) & !redirect_i;
    assign out_valid_o = buf_valid | bypass;
    assign out_pc_o    = buf_valid ? pc_mem[rd_q]
                       : bypass    ? tag_mem[tag_rd_q] : '0;
    assign out_instr_o = buf_valid ? instr_mem[rd_q]
                       : bypass    ? mem_rdata_i : '0;
`else
    assign bypass      = 1'b0;
    assign out_valid_o = buf_valid;
    assign out_pc_o    = buf_valid ? pc_mem[rd_q] : '0;
    assign out_instr_o = buf_valid ? instr_mem[rd_q] : '0;
`endif

    assign count_o = count_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fpc_q     <= RESET_PC;
            tag_rd_q  <= '0;
            tag_wr_q  <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
            count_q   <= '0;
            outst_q   <= '0;
            discard_q <= '0;
        end else if (redirect_i) begin
            // responses still in flight must be drained and dropped
            fpc_q     <= {redirect_pc_i[31:2], 2'b00};
            tag_rd_q  <= '0;
            tag_wr_q  <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
            count_q   <= '0;
            outst_q   <= '0;
            discard_q <= inflight
                       - CW'(mem_rvalid_i && (inflight != '0));
        end else begin
            if (accept) begin
                fpc_q    <= fpc_q + 32'd4;
                tag_wr_q <= tag_wr_q + 1'b1;
            end
            if (rsp_take) tag_rd_q <= tag_rd_q + 1'b1;
            if (rsp_drop) discard_q <= discard_q - 1'b1;
            if (push) wr_q <= wr_q + 1'b1;
            if (pop) rd_q <= rd_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
            outst_q <= outst_q + CW'(accept) - CW'(rsp_take);
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) tag_mem[tag_wr_q] <= fpc_q;
        if (push) begin
            pc_mem[wr_q]    <= tag_mem[tag_rd_q];
            instr_mem[wr_q] <= mem_rdata_i;
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: scoreboard bench for fetch_buffer with an in-order
// memory model; honours FETCH_BUFFER_BYPASS_EN when defined.
module tb_fetch_buffer;

    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [31:0] RESET_PC = 32'h0;
`ifdef FETCH_BUFFER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic          redirect_i = 1'b0;
    logic [31:0]   redirect_pc_i = '0;
    logic          mem_req_o;
    logic [31:0]   mem_addr_o;
    logic          mem_ack_i = 1'b0;
    logic          mem_rvalid_i = 1'b0;
    logic [31:0]   mem_rdata_i = '0;
    logic          out_valid_o;
    logic [31:0]   out_pc_o;
    logic [31:0]   out_instr_o;
    logic          out_ready_i = 1'b0;
    logic [CW-1:0] count_o;

    fetch_buffer #(
        .DEPTH(DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk_i(clk_i),
        .rst_n_i(rst_n_i),
        .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .mem_req_o(mem_req_o),
        .mem_addr_o(mem_addr_o),
        .mem_ack_i(mem_ack_i),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i),
        .out_valid_o(out_valid_o),
        .out_pc_o(out_pc_o),
        .out_instr_o(out_instr_o),
        .out_ready_i(out_ready_i),
        .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] addr;
        int          ep;
        int          due;
    } req_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    req_t        infl[$];
    ent_t        exp_q[$];
    logic [31:0] pop_log[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          lat = 1;
    int          reqs = 0;
    logic [31:0] exp_fpc = RESET_PC;
    logic        drv_ack = 1'b0;
    logic        drv_ready = 1'b0;
    logic        drv_redir = 1'b0;
    logic        drv_spur = 1'b0;
    logic [31:0] drv_rpc = '0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'h0000_0400) return 32'h0050_0093;
        return a ^ 32'h5a5a_0000;
    endfunction

    task automatic step();
        req_t        r;
        ent_t        e;
        int          n_before;
        int          cur_out;
        int          stale;
        logic        pushed;
        logic        exp_req;
        logic        exp_v;
        logic [CW-1:0] exp_cnt;
        @(negedge clk_i);
        cyc++;
        mem_ack_i     = drv_ack;
        out_ready_i   = drv_ready;
        redirect_i    = drv_redir;
        redirect_pc_i = drv_rpc;
        mem_rvalid_i  = 1'b0;
        mem_rdata_i   = '0;
        n_before = exp_q.size();
        cur_out = 0;
        stale = 0;
        foreach (infl[i]) begin
            if (infl[i].ep == epoch) cur_out++;
            else stale++;
        end
        exp_req = !drv_redir && (stale == 0)
                && (n_before + cur_out < DEPTH);
        pushed = 1'b0;
        if (infl.size() > 0 && infl[0].due <= cyc) begin
            r = infl.pop_front();
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = mem_data(r.addr);
            if (r.ep == epoch && !drv_redir) begin
                e.pc    = r.addr;
                e.instr = mem_data(r.addr);
                exp_q.push_back(e);
                pushed = 1'b1;
            end
        end else if (drv_spur) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = 32'hbad0_0bad;
        end
        #1;
        exp_cnt = CW'(n_before);
        checks++;
        if (count_o !== exp_cnt) begin
            errors++;
            $display("FAIL count @%0d: got %0d expected %0d",
                     cyc, count_o, exp_cnt);
        end
        checks++;
        if (mem_req_o !== exp_req) begin
            errors++;
            $display("FAIL mem_req @%0d: got %b expected %b",
                     cyc, mem_req_o, exp_req);
        end
        if (mem_req_o === 1'b1) begin
            checks++;
            if (mem_addr_o !== exp_fpc) begin
                errors++;
                $display("FAIL mem_addr @%0d: got %h expected %h",
                         cyc, mem_addr_o, exp_fpc);
            end
        end
        exp_v = !drv_redir
              && ((n_before > 0) || (BYP && pushed));
        checks++;
        if (out_valid_o !== exp_v) begin
            errors++;
            $display("FAIL out_valid @%0d: got %b expected %b",
                     cyc, out_valid_o, exp_v);
        end
        if (out_valid_o === 1'b1 && out_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL extra_out @%0d: got pc %h expected none",
                         cyc, out_pc_o);
            end else begin
                e = exp_q.pop_front();
                if (out_pc_o !== e.pc || out_instr_o !== e.instr) begin
                    errors++;
                    $display("FAIL out_entry @%0d: got %h/%h expected %h/%h",
                             cyc, out_pc_o, out_instr_o, e.pc, e.instr);
                end
            end
            pop_log.push_back(out_pc_o);
        end
        if (mem_req_o === 1'b1 && mem_ack_i) begin
            r.addr = exp_fpc;
            r.ep   = epoch;
            r.due  = cyc + lat;
            infl.push_back(r);
            exp_fpc = exp_fpc + 32'd4;
            reqs++;
        end
        if (drv_redir) begin
            exp_q.delete();
            epoch++;
            exp_fpc = {drv_rpc[31:2], 2'b00};
        end
    endtask

    task automatic reset_assert();
        @(negedge clk_i);
        rst_n_i = 1'b0;
        mem_ack_i = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i = '0;
        redirect_i = 1'b0;
        out_ready_i = 1'b0;
        infl.delete();
        exp_q.delete();
        epoch++;
        exp_fpc = RESET_PC;
        drv_redir = 1'b0;
        drv_spur = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    task automatic reset_release();
        @(posedge clk_i);
        #2;
        rst_n_i = 1'b1;
    endtask

    task automatic test_reset();
        reset_assert();
        checks += 6;
        if (mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_req: got %b expected 0", mem_req_o);
        end
        if (out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_valid: got %b expected 0", out_valid_o);
        end
        if (count_o !== '0) begin
            errors++;
            $display("FAIL rst_count: got %0d expected 0", count_o);
        end
        if (out_pc_o !== '0) begin
            errors++;
            $display("FAIL rst_pc: got %h expected 0", out_pc_o);
        end
        if (out_instr_o !== '0) begin
            errors++;
            $display("FAIL rst_instr: got %h expected 0", out_instr_o);
        end
        if (mem_addr_o !== RESET_PC) begin
            errors++;
            $display("FAIL rst_addr: got %h expected %h",
                     mem_addr_o, RESET_PC);
        end
        reset_release();
    endtask

    task automatic test_stream();
        int gaps;
        bit started;
        logic [31:0] want;
        reset_assert();
        reset_release();
        lat = 1;
        drv_ack = 1'b1;
        drv_ready = 1'b1;
        pop_log.delete();
        step();
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== RESET_PC) begin
            errors++;
            $display("FAIL first_req: got %b/%h expected 1/%h",
                     mem_req_o, mem_addr_o, RESET_PC);
        end
        gaps = 0;
        started = 0;
        repeat (24) begin
            step();
            if (started && out_valid_o !== 1'b1) gaps++;
            if (out_valid_o === 1'b1) started = 1;
        end
        checks++;
        if (gaps != 0) begin
            errors++;
            $display("FAIL stream_gaps: got %0d expected 0", gaps);
        end
        checks++;
        if (pop_log.size() < 20) begin
            errors++;
            $display("FAIL stream_len: got %0d expected >=20",
                     pop_log.size());
        end
        foreach (pop_log[i]) begin
            want = RESET_PC + 32'(4 * i);
            checks++;
            if (pop_log[i] !== want) begin
                errors++;
                $display("FAIL stream_pc[%0d]: got %h expected %h",
                         i, pop_log[i], want);
            end
        end
    endtask

    task automatic test_stall();
        reset_assert();
        reset_release();
        lat = 1;
        drv_ack = 1'b1;
        drv_ready = 1'b0;
        reqs = 0;
        repeat (10) step();
        checks += 3;
        if (reqs != DEPTH) begin
            errors++;
            $display("FAIL stall_reqs: got %0d expected %0d", reqs, DEPTH);
        end
        if (count_o !== CW'(DEPTH)) begin
            errors++;
            $display("FAIL stall_count: got %0d expected %0d",
                     count_o, DEPTH);
        end
        if (mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_req: got %b expected 0", mem_req_o);
        end
        drv_spur = 1'b1;
        step();
        drv_spur = 1'b0;
        checks++;
        if (out_pc_o !== RESET_PC
            || out_instr_o !== mem_data(RESET_PC)) begin
            errors++;
            $display("FAIL stall_hold: got %h/%h expected %h/%h",
                     out_pc_o, out_instr_o, RESET_PC, mem_data(RESET_PC));
        end
        drv_ready = 1'b1;
        step();
        checks++;
        if (mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_first_pop_req: got %b expected 0",
                     mem_req_o);
        end
        repeat (12) step();
    endtask

    task automatic test_redirect();
        reset_assert();
        reset_release();
        lat = 3;
        drv_ack = 1'b1;
        drv_ready = 1'b1;
        step();
        step();
        drv_redir = 1'b1;
        drv_rpc = 32'h0000_0103;
        step();
        drv_redir = 1'b0;
        pop_log.delete();
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (mem_rvalid_i !== 1'b1 || mem_req_o !== 1'b0) begin
                errors++;
                $display("FAIL redir_drop[%0d]: got rv %b req %b expected 1/0",
                         i, mem_rvalid_i, mem_req_o);
            end
        end
        step();
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100) begin
            errors++;
            $display("FAIL redir_req: got %b/%h expected 1/00000100",
                     mem_req_o, mem_addr_o);
        end
        repeat (10) step();
        checks++;
        if (pop_log.size() == 0 || pop_log[0] !== 32'h100) begin
            errors++;
            $display("FAIL redir_first_pc: got %h expected 00000100",
                     pop_log.size() ? pop_log[0] : 32'hx);
        end
    endtask

    task automatic test_double_redirect();
        int bad;
        reset_assert();
        reset_release();
        lat = 2;
        drv_ack = 1'b1;
        drv_ready = 1'b1;
        repeat (5) step();
        drv_redir = 1'b1;
        drv_rpc = 32'h0000_0200;
        step();
        drv_rpc = 32'h0000_0300;
        step();
        drv_redir = 1'b0;
        pop_log.delete();
        repeat (15) step();
        checks++;
        if (pop_log.size() == 0 || pop_log[0] !== 32'h300) begin
            errors++;
            $display("FAIL dbl_first_pc: got %h expected 00000300",
                     pop_log.size() ? pop_log[0] : 32'hx);
        end
        bad = 0;
        foreach (pop_log[i])
            if (pop_log[i] >= 32'h200 && pop_log[i] < 32'h300) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL dbl_stale: got %0d entries expected 0", bad);
        end
    endtask

    task automatic test_push_pop();
        reset_assert();
        reset_release();
        lat = 1;
        drv_ack = 1'b1;
        drv_ready = 1'b0;
        repeat (4) step();
        drv_ready = 1'b1;
        step();
        checks++;
        if (count_o !== CW'(3) || mem_rvalid_i !== 1'b1
            || out_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL pp_setup: got cnt %0d rv %b v %b expected 3/1/1",
                     count_o, mem_rvalid_i, out_valid_o);
        end
        step();
        checks++;
        if (count_o !== CW'(3)) begin
            errors++;
            $display("FAIL pp_count: got %0d expected 3", count_o);
        end
        lat = 2;
        repeat (60) begin
            drv_ready = ($urandom_range(0, 3) != 0);
            drv_ack = ($urandom_range(0, 4) != 0);
            step();
        end
        drv_ready = 1'b1;
        drv_ack = 1'b0;
        repeat (8) step();
        checks++;
        if (exp_q.size() != 0 || count_o !== '0) begin
            errors++;
            $display("FAIL pp_drain: got %0d/%0d expected 0/0",
                     exp_q.size(), count_o);
        end
    endtask

    task automatic test_bypass();
        reset_assert();
        reset_release();
        lat = 1;
        drv_ack = 1'b0;
        drv_ready = 1'b1;
        drv_redir = 1'b1;
        drv_rpc = 32'h0000_0400;
        step();
        drv_redir = 1'b0;
        drv_ack = 1'b1;
        step();
        drv_ack = 1'b0;
        step();
        checks++;
`ifdef FETCH_BUFFER_BYPASS_EN
        if (out_valid_o !== 1'b1 || out_instr_o !== 32'h0050_0093
            || out_pc_o !== 32'h400) begin
            errors++;
            $display("FAIL bypass_same: got %b/%h/%h expected 1/00000400/00500093",
                     out_valid_o, out_pc_o, out_instr_o);
        end
`else
        if (out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL bypass_same: got %b expected 0", out_valid_o);
        end
`endif
        step();
        checks++;
`ifdef FETCH_BUFFER_BYPASS_EN
        if (out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL bypass_next: got %b expected 0", out_valid_o);
        end
`else
        if (out_valid_o !== 1'b1 || out_instr_o !== 32'h0050_0093
            || out_pc_o !== 32'h400) begin
            errors++;
            $display("FAIL bypass_next: got %b/%h/%h expected 1/00000400/00500093",
                     out_valid_o, out_pc_o, out_instr_o);
        end
`endif
        repeat (3) step();
    endtask

    task automatic test_reset_mid();
        lat = 2;
        drv_ack = 1'b1;
        drv_ready = 1'b0;
        repeat (3) step();
        test_reset();
        test_stream();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_double_redirect();
        test_push_pop();
        test_bypass();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
